// File: rtl/oram_arb_if.sv
// PPU write / host read / RAM port bundle for the oram_arb arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface oram_arb_if;
  logic        i_wr_req;
  logic [12:0] i_wr_addr;
  logic [7:0]  i_wr_data;
  logic        o_wr_full;
  logic        i_rd_req;
  logic [12:0] i_rd_addr;
  logic        o_rd_gnt;
  logic        o_rd_vld;
  logic [7:0]  o_rd_data;
  logic        o_ram_we;
  logic [12:0] o_ram_addr;
  logic [7:0]  o_ram_wdata;
  logic [7:0]  i_ram_rdata;
  logic        o_idle;

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_ram_rdata,
    output o_wr_full, o_rd_gnt, o_rd_vld, o_rd_data, o_ram_we, o_ram_addr,
           o_ram_wdata, o_idle
  );

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_ram_rdata,
    input  o_wr_full, o_rd_gnt, o_rd_vld, o_rd_data, o_ram_we, o_ram_addr,
           o_ram_wdata, o_idle
  );
endinterface

// File: rtl/oram_arb.sv
// Single-port RAM arbiter: buffered PPU writes share one RAM slot per cycle with
// host reads; reads win unless they hit a buffered address, the buffer is full,
// or they have starved pending writes for RD_STREAK consecutive grants.
module oram_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_STREAK  = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  oram_arb_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(RD_STREAK + 1);

  typedef enum logic [1:0] {
    SLOT_NONE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  logic [12:0]   addr_q [FIFO_DEPTH];
  logic [7:0]    data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q;
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          rd_vld_q;
  logic [7:0]    rd_hold_q;

  logic          full_s;
  logic          empty_s;
  logic          hazard_s;
  logic          streak_block_s;
  logic          push_s;
  logic          pop_s;
  slot_e         slot_s;
  logic [12:0]   ram_addr_s;
  logic [7:0]    ram_wdata_s;

  assign full_s         = (count_q == CW'(FIFO_DEPTH));
  assign empty_s        = (count_q == {CW{1'b0}});
  assign streak_block_s = (streak_q == SW'(RD_STREAK)) && !empty_s;

  // Address hazard against every live buffered write, not just the head.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      hazard_s = hazard_s | (vld_q[i] && (addr_q[i] == bus.i_rd_addr));
    end
  end

  // Slot arbitration; nothing is granted while reset is held.
  always_comb begin
    slot_s = SLOT_NONE;
    if (i_rst) begin
      slot_s = SLOT_NONE;
    end else if (bus.i_rd_req && !hazard_s && !full_s && !streak_block_s) begin
      slot_s = SLOT_READ;
    end else if (!empty_s) begin
      slot_s = SLOT_WRITE;
    end else begin
      slot_s = SLOT_NONE;
    end
  end

  assign push_s = bus.i_wr_req && !full_s && !i_rst;
  assign pop_s  = (slot_s == SLOT_WRITE);

  // RAM port steering for the selected slot.
  always_comb begin
    ram_addr_s  = 13'h0000;
    ram_wdata_s = 8'h00;
    case (slot_s)
      SLOT_READ: begin
        ram_addr_s  = bus.i_rd_addr;
        ram_wdata_s = 8'h00;
      end
      SLOT_WRITE: begin
        ram_addr_s  = addr_q[head_q];
        ram_wdata_s = data_q[head_q];
      end
      default: begin
        ram_addr_s  = 13'h0000;
        ram_wdata_s = 8'h00;
      end
    endcase
  end

  // Occupancy and read-streak next state.
  always_comb begin
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    streak_d = streak_q;
    if (pop_s || empty_s) begin
      streak_d = {SW{1'b0}};
    end else if ((slot_s == SLOT_READ) && (streak_q != SW'(RD_STREAK))) begin
      streak_d = streak_q + SW'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  // Write buffer storage, pointers and counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q   <= {AW{1'b0}};
      tail_q   <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      streak_q <= {SW{1'b0}};
      vld_q    <= {FIFO_DEPTH{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= 13'h0000;
        data_q[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        addr_q[tail_q] <= bus.i_wr_addr;
        data_q[tail_q] <= bus.i_wr_data;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + AW'(1);
      end
      if (pop_s) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + AW'(1);
      end
      count_q  <= count_d;
      streak_q <= streak_d;
    end
  end

  // Read return tracking; the last returned byte is held between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_vld_q  <= 1'b0;
      rd_hold_q <= 8'h00;
    end else begin
      rd_vld_q <= (slot_s == SLOT_READ);
      if (rd_vld_q) begin
        rd_hold_q <= bus.i_ram_rdata;
      end
    end
  end

  assign bus.o_wr_full   = full_s;
  assign bus.o_rd_gnt    = (slot_s == SLOT_READ);
  assign bus.o_ram_we    = pop_s;
  assign bus.o_ram_addr  = ram_addr_s;
  assign bus.o_ram_wdata = ram_wdata_s;
  assign bus.o_rd_vld    = rd_vld_q;
  assign bus.o_rd_data   = rd_vld_q ? bus.i_ram_rdata : rd_hold_q;
  assign bus.o_idle      = empty_s && !rd_vld_q;
endmodule

// File: tb/tb_oram_arb.sv
// Directed and randomized bench for oram_arb against a queue-based reference
// model of the arbitration rules plus a 1-cycle-latency RAM.
module tb_oram_arb;
  localparam int DEPTH = 4;
  localparam int RS    = 4;

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } ent_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  oram_arb_if bus ();

  oram_arb #(.FIFO_DEPTH(DEPTH), .RD_STREAK(RS)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Environment RAM: synchronous write, registered read.
  logic [7:0] ram [8192];
  always @(posedge i_clk) begin
    if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
    bus.i_ram_rdata <= ram[bus.o_ram_addr];
  end

  // Reference model state
  ent_t       q[$];
  int         streak;
  bit         m_vld;
  logic [7:0] m_data;
  logic [7:0] exp_mem [8192];

  int checks   = 0;
  int failures = 0;
  int n_we     = 0;
  bit saw_full = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    streak = 0;
    m_vld  = 1'b0;
    m_data = 8'h00;
  endtask

  task automatic step(input logic wr, input logic [12:0] wa, input logic [7:0] wd,
                      input logic rd, input logic [12:0] ra,
                      output logic acc_push, output logic acc_rd);
    bit full, hz, rsel, wsel;
    int size0;
    logic [12:0] eaddr;
    ent_t head;
    bus.i_wr_req  = wr;
    bus.i_wr_addr = wa;
    bus.i_wr_data = wd;
    bus.i_rd_req  = rd;
    bus.i_rd_addr = ra;
    size0 = q.size();
    full  = (size0 == DEPTH);
    hz    = 1'b0;
    foreach (q[k]) if (q[k].a == ra) hz = 1'b1;
    rsel  = rd && !hz && !full && !(streak == RS && size0 > 0);
    wsel  = !rsel && (size0 > 0);
    head  = (size0 > 0) ? q[0] : '{13'h0, 8'h0};
    eaddr = rsel ? ra : (wsel ? head.a : 13'h0000);
    #2;
    chk("rd_gnt",   16'(bus.o_rd_gnt),   16'(rsel));
    chk("ram_we",   16'(bus.o_ram_we),   16'(wsel));
    chk("ram_addr", 16'(bus.o_ram_addr), 16'(eaddr));
    if (wsel) chk("ram_wdata", 16'(bus.o_ram_wdata), 16'(head.d));
    chk("wr_full",  16'(bus.o_wr_full),  16'(full));
    chk("rd_vld",   16'(bus.o_rd_vld),   16'(m_vld));
    chk("rd_data",  16'(bus.o_rd_data),  16'(m_data));
    chk("idle",     16'(bus.o_idle),     16'(size0 == 0 && !m_vld));
    if (bus.o_wr_full) saw_full = 1'b1;
    if (bus.o_ram_we) n_we++;
    @(posedge i_clk);
    if (wsel) begin
      exp_mem[head.a] = head.d;
      head = q.pop_front();
    end
    if (wr && !full) q.push_back('{wa, wd});
    if (wsel || size0 == 0) streak = 0;
    else if (rsel && streak < RS) streak++;
    m_vld = rsel;
    if (rsel) m_data = exp_mem[ra];
    acc_push = wr && !full;
    acc_rd   = rsel;
    @(negedge i_clk);
  endtask

  initial begin
    logic ap, ar;
    int k, waited, base;
    logic rd_pend, wr_pend;
    logic [12:0] ra, wa;
    logic [7:0] wd;

    for (int i = 0; i < 8192; i++) begin
      ram[i]     = 8'((i * 7) + 3);
      exp_mem[i] = 8'((i * 7) + 3);
    end
    ram[13'h1FFF]     = 8'h3C;
    exp_mem[13'h1FFF] = 8'h3C;
    model_reset();

    // Reset state with requests already asserted
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 13'h0011; bus.i_wr_data = 8'h77;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 13'h0022;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_gnt",   16'(bus.o_rd_gnt),   16'h0);
    chk("rst_we",    16'(bus.o_ram_we),   16'h0);
    chk("rst_addr",  16'(bus.o_ram_addr), 16'h0);
    chk("rst_full",  16'(bus.o_wr_full),  16'h0);
    chk("rst_vld",   16'(bus.o_rd_vld),   16'h0);
    chk("rst_data",  16'(bus.o_rd_data),  16'h0);
    chk("rst_idle",  16'(bus.o_idle),     16'h1);
    i_rst = 1'b0;

    // Write-only stream; first push right after reset release
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 13'(i), 8'hA0 + 8'(i), 1'b0, 13'h0, ap, ar);
      chk("wo_push_acc", 16'(ap), 16'h1);
    end
    repeat (3) step(1'b0, 13'h0, 8'h0, 1'b0, 13'h0, ap, ar);
    chk("wo_idle", 16'(bus.o_idle), 16'h1);
    chk("wo_we_pulses", 16'(n_we), 16'd6);
    for (int i = 0; i < 6; i++) chk("wo_ram", 16'(ram[i]), 16'hA0 + 16'(i));

    // Read latency on an idle block
    step(1'b0, 13'h0, 8'h0, 1'b1, 13'h1FFF, ap, ar);
    chk("lat_gnt", 16'(ar), 16'h1);
    chk("lat_vld", 16'(bus.o_rd_vld), 16'h1);
    chk("lat_data", 16'(bus.o_rd_data), 16'h3C);
    step(1'b0, 13'h0, 8'h0, 1'b0, 13'h0, ap, ar);
    chk("lat_vld_drop", 16'(bus.o_rd_vld), 16'h0);

    // Hazard: read waits for the matching buffered write
    step(1'b1, 13'h0100, 8'h5A, 1'b0, 13'h0, ap, ar);
    waited = 0;
    ar = 1'b0;
    while (!ar && waited < 10) begin
      step(1'b0, 13'h0, 8'h0, 1'b1, 13'h0100, ap, ar);
      waited++;
    end
    chk("hz_granted", 16'(ar), 16'h1);
    chk("hz_waited", 16'(waited), 16'd2);
    chk("hz_data", 16'(bus.o_rd_data), 16'h5A);
    step(1'b0, 13'h0, 8'h0, 1'b0, 13'h0, ap, ar);

    // Starvation bound with a continuously held read
    base = n_we;
    step(1'b1, 13'h0300, 8'h31, 1'b1, 13'h0040, ap, ar);
    step(1'b1, 13'h0301, 8'h32, 1'b1, 13'h0040, ap, ar);
    repeat (14) step(1'b0, 13'h0, 8'h0, 1'b1, 13'h0040, ap, ar);
    chk("starve_writes", 16'(n_we - base), 16'd2);

    // Full: pushes held while reads dominate
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      step(1'b1, 13'h0600 + 13'(k), 8'hC0 + 8'(k), 1'b1, 13'h0050, ap, ar);
      if (ap) k++;
    end
    chk("full_seen", 16'(saw_full), 16'h1);
    chk("full_all_pushed", 16'(k), 16'd6);
    repeat (8) step(1'b0, 13'h0, 8'h0, 1'b0, 13'h0, ap, ar);
    chk("full_drained_idle", 16'(bus.o_idle), 16'h1);

    // Randomized traffic over a small address window to provoke hazards
    rd_pend = 1'b0; wr_pend = 1'b0; ra = 13'h0; wa = 13'h0; wd = 8'h0;
    for (int c = 0; c < 300; c++) begin
      if (!rd_pend && ($urandom_range(2) == 0)) begin
        rd_pend = 1'b1;
        ra = 13'h1000 + 13'($urandom_range(7));
      end
      if (!wr_pend && ($urandom_range(1) == 0)) begin
        wr_pend = 1'b1;
        wa = 13'h1000 + 13'($urandom_range(7));
        wd = 8'($urandom);
      end
      step(wr_pend, wa, wd, rd_pend, ra, ap, ar);
      if (ap) wr_pend = 1'b0;
      if (ar) rd_pend = 1'b0;
    end
    repeat (6) step(1'b0, 13'h0, 8'h0, 1'b0, 13'h0, ap, ar);

    // Reset mid-stream: buffered writes plus a read in flight
    for (int i = 0; i < 3; i++) step(1'b1, 13'h0700 + 13'(i), 8'h90 + 8'(i), 1'b1, 13'h0060, ap, ar);
    step(1'b0, 13'h0, 8'h0, 1'b1, 13'h0060, ap, ar);
    chk("mid_inflight", 16'(bus.o_rd_vld), 16'h1);
    chk("mid_buffered", 16'(bus.o_idle), 16'h0);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_vld", 16'(bus.o_rd_vld), 16'h0);
    chk("mid_rst_idle", 16'(bus.o_idle), 16'h1);
    chk("mid_rst_we", 16'(bus.o_ram_we), 16'h0);
    chk("mid_rst_gnt", 16'(bus.o_rd_gnt), 16'h0);
    model_reset();
    bus.i_rd_req = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    base = n_we;
    repeat (6) step(1'b0, 13'h0, 8'h0, 1'b0, 13'h0, ap, ar);
    chk("mid_no_we", 16'(n_we - base), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oram_arb.md
ORAM_ARB -- requirements
Module: oram_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter RD_STREAK, default 4, max consecutive read grants while writes are pending.
REQ-003 SHALL have i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_wr_req  input  1  PPU write request.
REQ-006 SHALL have i_wr_addr  input  13  PPU write address.
REQ-007 SHALL have i_wr_data  input  8  PPU write byte.
REQ-008 SHALL have o_wr_full  output  1  write buffer full; push refused.
REQ-009 SHALL have i_rd_req  input  1  host read request; held with address until granted.
REQ-010 SHALL have i_rd_addr  input  13  host read address.
REQ-011 SHALL have o_rd_gnt  output  1  read granted this cycle (combinational).
REQ-012 SHALL have o_rd_vld  output  1  read data valid.
REQ-013 SHALL have o_rd_data  output  8  read byte.
REQ-014 SHALL have o_ram_we  output  1  RAM write enable.
REQ-015 SHALL have o_ram_addr  output  13  RAM address.
REQ-016 SHALL have o_ram_wdata  output  8  RAM write data.
REQ-017 SHALL have i_ram_rdata  input  8  RAM read data, 1-cycle latency after address.
REQ-018 SHALL have o_idle  output  1  buffer empty and no read in flight.

Function
REQ-019 Push: i_wr_req && !o_wr_full stores {addr,data} at FIFO tail at the clock edge; a request while full is dropped, and the PPU must hold it.
REQ-020 o_wr_full SHALL equal (count == FIFO_DEPTH) from registered count; a pop in the same cycle does not unblock a push.
REQ-021 Arbiter per cycle, exactly one RAM slot: NONE, READ, or WRITE; the slot is WRITE only if the FIFO is non-empty.
REQ-022 READ is chosen when i_rd_req && !hazard && !(count == FIFO_DEPTH) && !(streak == RD_STREAK && count > 0); otherwise WRITE if count > 0; otherwise NONE.
REQ-023 hazard SHALL be 1 when i_rd_addr equals the address of any valid FIFO entry; the read then waits until the matching entries drain.
REQ-024 streak counter: +1 on READ grant while count > 0; cleared on WRITE slot or when count == 0; saturates at RD_STREAK.
REQ-025 READ slot: o_rd_gnt=1, o_ram_we=0, o_ram_addr=i_rd_addr; next cycle o_rd_vld=1, o_rd_data=i_ram_rdata, otherwise o_rd_data holds its last value.
REQ-026 WRITE slot: o_ram_we=1, o_ram_addr/o_ram_wdata=FIFO head; head pops at the edge.
REQ-027 NONE slot: o_ram_we=0, o_ram_addr=0, o_rd_gnt=0.
REQ-028 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-029 A push in cycle N SHALL be eligible for pop no earlier than cycle N+1 (no bypass).
REQ-030 o_idle = (count == 0) && !o_rd_vld.

Reset
REQ-031 While i_rst=1: FIFO empty, pointers/count/streak=0, o_wr_full=0, o_rd_vld=0, o_rd_data=0, o_ram_we=0, o_rd_gnt=0, o_idle=1.
REQ-032 Reset asserted mid-operation SHALL discard buffered writes and any in-flight read valid immediately (asynchronously).
REQ-033 First push SHALL be accepted on the first rising edge after i_rst deasserts.

Verification
REQ-034 Write-only: 6 pushes addr 0..5, data 0xA0..0xA5, no reads -> o_ram_we pulses in order with matching addr/data, no drops, o_idle=1 afterward.
REQ-035 Full: hold i_wr_req with reads blocking (RD_STREAK path disabled by continuous hazard-free reads) -> o_wr_full=1 at count 4, 5th push held until a WRITE slot, then accepted.
REQ-036 Starvation: FIFO holds 2 entries, i_rd_req held continuously -> exactly 4 READ grants, 1 WRITE, 4 READ, 1 WRITE, then reads only.
REQ-037 Hazard: pending write addr 0x0100 data 0x5A, read 0x0100 -> o_rd_gnt stays 0 until that write issues; o_rd_vld returns 0x5A (RAM model).
REQ-038 Read latency: idle block, read 0x1FFF with RAM returning 0x3C -> o_rd_gnt in cycle N, o_rd_vld=1 with 0x3C in N+1 only.
REQ-039 Reset mid-stream: 3 entries buffered plus a read in flight, pulse i_rst -> o_rd_vld=0, o_idle=1, no further o_ram_we pulses.
